uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
Serial transmit path of the UART: a byte FIFO written from the register interface, plus a serializer that sends start, 5–8 data bits LSB-first, optional parity and 1/1.5/2 stop bits on stx_pad_o. It is paced by the same 16x-baud `enable` strobe as the receive path and uses the same LCR encoding. It reports FIFO fill level and empty status for the LSR (THRE/TEMT) and for interrupt logic.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries (power of 2).
- FIFO_POINTER_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock
- wb_rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- lcr  in  8  line control: [1:0] word length (00=5 … 11=8), [2] stop bits, [3] PE, [4] EP, [5] SP, [6] BC (break)
- tf_push  in  1  write strobe for the TX FIFO, one clk per byte
- wb_dat_i  in  8  byte written on tf_push
- enable  in  1  16x-baud tick, single-clk pulse
- tx_reset  in  1  synchronous FIFO clear (FCR[2])
- stx_pad_o  out  1  serial output, registered
- tf_count  out  FIFO_POINTER_W+1  FIFO occupancy
- tstate  out  3  current FSM state, for debug
- thre  out  1  FIFO empty
- temt  out  1  FIFO empty and FSM in s_idle with no frame in flight

Behaviour:
- Reset values: stx_pad_o=1, tstate=s_idle, tf_count=0, thre=1, temt=1, shift register=0, counter16=0, bit counter=0.
- All FSM activity advances only on clk edges where enable=1. A bit cell lasts exactly 16 enable ticks; the 1.5-stop cell lasts 24.
- States, 3-bit encoding:
  - s_idle=0: stx=1. On enable with tf_count≠0: latch FIFO head into shift, pulse internal pop (1 clk), compute parity, set counter16=15, go to s_start.
  - s_start=1: stx=0. Go to s_data when counter16==0; reload counter16=15 and bit counter = word length−1.
  - s_data=2: stx=shift[0]. At counter16==0: shift right by 1, reload 15.
    - If bit counter≠0, decrement it and stay.
    - Otherwise go to s_parity if lcr[3]=1, else to s_stop.
  - s_parity=3: stx=parity bit for 16 ticks, then go to s_stop.
  - s_stop=4: stx=1. Length:
    - lcr[2]=0: 16 ticks.
    - lcr[2]=1 with 5-bit words: 24 ticks.
    - lcr[2]=1 with 6–8-bit words: 32 ticks.
    - counter16 is 5 bits wide to cover 31.
    - At the end: if tf_count≠0, load the next byte, pop, and go straight to s_start (back-to-back frames, no idle gap); otherwise go to s_idle.
- Parity is computed over the masked data bits only (unused upper bits are treated as 0):
  - SP=0, EP=1: parity = ^data (even).
  - SP=0, EP=0: parity = ~^data (odd).
  - SP=1: parity = ~EP (EP=0 gives 1, EP=1 gives 0).
- lcr is sampled live each cell. Software must not change it mid-frame; if it does, the result is defined but unspecified.
- Break: lcr[6]=1 forces stx_pad_o=0 from the next clk, independent of enable. The FSM keeps running underneath. Releasing break restores stx_pad_o to the FSM value on the next clk.
- FIFO:
  - Push when full is dropped silently; count stays at FIFO_DEPTH.
  - Push and pop in the same clk: both occur, count unchanged.
  - Push to an empty FIFO is visible to s_idle on the next clk.
- tx_reset: clears pointers and count in 1 clk. The frame in flight completes because its data is already in the shift register.
  - Push coincident with tx_reset: reset wins; the byte is dropped.
- enable=0 for any length freezes the FSM and holds stx_pad_o steady.
- Reset assertion mid-frame: outputs return to reset values immediately (asynchronous).

Decomposition:
- uart_defines gains:
  - UART_LC_BC, UART_LC_SB bit indices (alongside the existing PE/EP/SP indices).
  - UART_FIFO_WIDTH=8.
  - TX state encodings st_idle..st_stop.
- One sub-module, uart_tfifo: 8-bit wide, FIFO_DEPTH entries, registered pointers, combinational head output, count output, fifo_reset input. The transmitter instantiates it and owns the pop.

Test Plan:
- lcr=8'h03 (8N1), push 8'hA5, enable every clk → stx: 0, then 1,0,1,0,0,1,0,1, then 1; each cell 16 ticks, 160 ticks total; temt rises 1 clk after the stop cell; thre=1 from the pop clk onward.
- lcr=8'h1A (7E1), push 8'h41 → 7 data bits 1,0,0,0,0,0,1, then parity 0; lcr=8'h0A (7O1), same byte → parity 1; lcr=8'h3A (stick, EP=1) → parity 0.
- lcr=8'h04 (5-bit, 1.5 stop), push 8'h1F → stop cell is 24 ticks; lcr=8'h07 → stop cell is 32 ticks.
- enable held 0, push 17 bytes 8'h00..8'h10 → tf_count=16; 8'h10 never appears on stx; back-to-back frames then go out with no idle gap between stop and start.
- Mid-frame on the 3rd data bit, set lcr[6] → stx=0 next clk; clear it → stx resumes at the correct bit position. Separately, assert tx_reset with 5 queued → current frame finishes, tf_count=0, then idle.
- Drop wb_rst_ni during s_data → stx_pad_o=1, tstate=0, tf_count=0 with no clk edge required.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: LCR bit indices, FIFO width, TX state encodings and parity helper.
package uart_transmitter_pkg;
  localparam int UART_LC_SB = 2;
  localparam int UART_LC_PE = 3;
  localparam int UART_LC_EP = 4;
  localparam int UART_LC_SP = 5;
  localparam int UART_LC_BC = 6;
  localparam int UART_FIFO_WIDTH = 8;
  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_start  = 3'd1,
    st_data   = 3'd2,
    st_parity = 3'd3,
    st_stop   = 3'd4
  } tx_state_e;
  // Bits above the configured word length never count toward parity.
  function automatic logic tx_parity(input logic [7:0] data, input logic [7:0] ctl);
    logic [7:0] m;
    m = data & (8'hFF >> (2'd3 - ctl[1:0]));
    return ctl[UART_LC_SP] ? ~ctl[UART_LC_EP] : (ctl[UART_LC_EP] ? ^m : ~^m);
  endfunction
endpackage

// File: rtl/uart_transmitter_tfifo.sv
// uart_tfifo: byte FIFO with registered pointers, combinational head and occupancy count.
module uart_tfifo
  import uart_transmitter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_POINTER_W = 4
) (
  input  logic                       clk,
  input  logic                       wb_rst_ni,
  input  logic                       fifo_reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [UART_FIFO_WIDTH-1:0] data_in,
  output logic [UART_FIFO_WIDTH-1:0] data_out,
  output logic [FIFO_POINTER_W:0]    count
);
  logic [UART_FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_POINTER_W-1:0] top_q, bottom_q;
  logic [FIFO_POINTER_W:0] count_q;
  logic push_ok, pop_ok;
  // A clear in the same clk as a push discards the byte.
  assign push_ok = push && !fifo_reset && count_q != (FIFO_POINTER_W+1)'(FIFO_DEPTH);
  assign pop_ok = pop && !fifo_reset && count_q != '0;
  assign data_out = mem_q[bottom_q];
  assign count = count_q;
  always_ff @(posedge clk)
    if (push_ok) mem_q[top_q] <= data_in;
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni || fifo_reset) begin
      top_q <= '0;
      bottom_q <= '0;
      count_q <= '0;
    end else begin
      top_q <= top_q + FIFO_POINTER_W'(push_ok);
      bottom_q <= bottom_q + FIFO_POINTER_W'(pop_ok);
      count_q <= count_q + (FIFO_POINTER_W+1)'(push_ok) - (FIFO_POINTER_W+1)'(pop_ok);
    end
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: TX FIFO plus serializer producing start, 5-8 data bits, optional parity
// and 1/1.5/2 stop bits on stx_pad_o, paced by the 16x-baud enable strobe.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_POINTER_W = 4
) (
  input  logic                    clk,
  input  logic                    wb_rst_ni,
  input  logic [7:0]              lcr,
  input  logic                    tf_push,
  input  logic [7:0]              wb_dat_i,
  input  logic                    enable,
  input  logic                    tx_reset,
  output logic                    stx_pad_o,
  output logic [FIFO_POINTER_W:0] tf_count,
  output logic [2:0]              tstate,
  output logic                    thre,
  output logic                    temt
);
  tx_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, stop_len;
  logic [2:0] bits_q, bits_d;
  logic [7:0] shift_q, shift_d, head;
  logic par_q, par_d, stx_q, line_d, load;
  uart_tfifo #(.FIFO_DEPTH(FIFO_DEPTH), .FIFO_POINTER_W(FIFO_POINTER_W)) u_fifo (
    .clk(clk),
    .wb_rst_ni(wb_rst_ni),
    .fifo_reset(tx_reset),
    .push(tf_push),
    .pop(load),
    .data_in(wb_dat_i),
    .data_out(head),
    .count(tf_count)
  );
  // Stop cell reload: 16 ticks, or 24 (5-bit words) / 32 ticks with the long-stop bit.
  assign stop_len = !lcr[UART_LC_SB] ? 5'd15 : (lcr[1:0] == 2'b00 ? 5'd23 : 5'd31);
  assign load = enable && tf_count != '0 && (state_q == st_idle || (state_q == st_stop && cnt_q == '0));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bits_d = bits_q;
    shift_d = shift_q;
    par_d = par_q;
    if (load) begin
      state_d = st_start;
      cnt_d = 5'd15;
      shift_d = head;
      par_d = tx_parity(head, lcr);
    end else if (enable && state_q != st_idle) begin
      if (cnt_q != '0) cnt_d = cnt_q - 5'd1;
      else begin
        case (state_q)
          st_start: begin
            state_d = st_data;
            cnt_d = 5'd15;
            bits_d = 3'(lcr[1:0]) + 3'd4;
          end
          st_data: begin
            shift_d = shift_q >> 1;
            cnt_d = 5'd15;
            if (bits_q != '0) bits_d = bits_q - 3'd1;
            else if (lcr[UART_LC_PE]) state_d = st_parity;
            else begin
              state_d = st_stop;
              cnt_d = stop_len;
            end
          end
          st_parity: begin
            state_d = st_stop;
            cnt_d = stop_len;
          end
          default: state_d = st_idle;
        endcase
      end
    end
    line_d = state_d == st_start ? 1'b0 :
             state_d == st_data ? shift_d[0] :
             state_d == st_parity ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state_q <= st_idle;
      cnt_q <= '0;
      bits_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      stx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bits_q <= bits_d;
      shift_q <= shift_d;
      par_q <= par_d;
      stx_q <= lcr[UART_LC_BC] ? 1'b0 : line_d;
    end
  assign stx_pad_o = stx_q;
  assign tstate = state_q;
  assign thre = tf_count == '0;
  assign temt = thre && state_q == st_idle;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a monitor decodes stx_pad_o cell by cell against
// frames computed from the line-format rules, while stimulus checks counts, flags and lengths.
module tb_uart_transmitter;
  logic clk = 0, wb_rst_ni = 1, tf_push = 0, enable = 0, tx_reset = 0;
  logic [7:0] lcr = 8'h03, wb_dat_i = 8'h00;
  logic stx_pad_o, thre, temt;
  logic [4:0] tf_count;
  logic [2:0] tstate;

  uart_transmitter dut (
    .clk(clk), .wb_rst_ni(wb_rst_ni), .lcr(lcr), .tf_push(tf_push), .wb_dat_i(wb_dat_i),
    .enable(enable), .tx_reset(tx_reset), .stx_pad_o(stx_pad_o), .tf_count(tf_count),
    .tstate(tstate), .thre(thre), .temt(temt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic [7:0] l; } frame_t;
  frame_t sb[$];
  int n_chk = 0, n_fail = 0, en_mode = 0, b2b = 0, idle_after = 0;
  bit en_seen = 0, mon_on = 1, brk_mask = 0;
  bit cv[12];
  int cl[12];
  int nc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic int data_bits(input logic [7:0] l);
    return 5 + int'(l[1:0]);
  endfunction
  function automatic int stop_ticks(input logic [7:0] l);
    return !l[2] ? 16 : (data_bits(l) == 5 ? 24 : 32);
  endfunction
  function automatic bit parity_of(input logic [7:0] d, input logic [7:0] l);
    int ones = 0;
    for (int i = 0; i < data_bits(l); i++) ones += int'(d[i]);
    if (l[5]) return !l[4];
    return l[4] ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction
  function automatic int frame_len(input logic [7:0] l);
    return 16 * (1 + data_bits(l) + int'(l[3])) + stop_ticks(l);
  endfunction

  task automatic model_cells(input frame_t f);
    nc = 0;
    cv[nc] = 0; cl[nc] = 16; nc++;
    for (int i = 0; i < data_bits(f.l); i++) begin cv[nc] = f.d[i]; cl[nc] = 16; nc++; end
    if (f.l[3]) begin cv[nc] = parity_of(f.d, f.l); cl[nc] = 16; nc++; end
    cv[nc] = 1; cl[nc] = stop_ticks(f.l); nc++;
  endtask

  initial forever begin
    @(negedge clk);
    enable = en_mode == 0 ? 1'b1 : en_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  always @(posedge clk) en_seen <= enable;

  task automatic next_tick();
    do @(negedge clk); while (!en_seen && mon_on);
  endtask

  initial begin
    frame_t f;
    bit pending = 0;
    int bad;
    forever begin
      if (!pending) @(negedge clk);
      pending = 0;
      if (mon_on && !brk_mask && stx_pad_o === 1'b0) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_start: got stx 0 with no frame queued, expected 1");
          for (int i = 0; i < 2000 && stx_pad_o !== 1'b1; i++) @(negedge clk);
        end else begin
          f = sb.pop_front();
          model_cells(f);
          for (int c = 0; c < nc && mon_on; c++) begin
            bad = 0;
            for (int t = 0; t < cl[c] && mon_on; t++) begin
              if (c != 0 || t != 0) next_tick();
              if (mon_on && !brk_mask && stx_pad_o !== cv[c]) bad++;
            end
            if (mon_on) begin
              n_chk++;
              if (bad != 0) begin
                n_fail++;
                $display("FAIL cell%0d byte %02h lcr %02h: %0d ticks wrong, expected %0b", c, f.d, f.l, bad, cv[c]);
              end
            end
          end
          if (mon_on) begin
            next_tick();
            if (stx_pad_o === 1'b0) begin pending = 1; b2b++; end
            else idle_after++;
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [7:0] l, input bit exp);
    @(negedge clk);
    wb_dat_i = d; tf_push = 1;
    @(negedge clk);
    tf_push = 0;
    if (exp) sb.push_back('{d, l});
  endtask

  task automatic wait_fall(input string name);
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (stx_pad_o === 1'b0) return;
    end
    chk({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_temt(input string name, output int ticks);
    ticks = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (en_seen) ticks++;
      if (temt === 1'b1) return;
    end
    chk({name, "_temt_timeout"}, 0, 1);
  endtask

  task automatic send_one(input logic [7:0] l, input logic [7:0] d);
    int ticks;
    lcr = l;
    push(d, l, 1);
    wait_fall("send");
    chk("thre_after_pop", thre, 1);
    chk("temt_busy", temt, 0);
    wait_temt("send", ticks);
    chk("frame_ticks", ticks, frame_len(l));
  endtask

  initial begin
    logic [15:0] dir [6];
    int ticks, k;
    logic [7:0] l;
    dir = '{16'h03A5, 16'h1A41, 16'h0A41, 16'h3A41, 16'h041F, 16'h071F};
    #1 wb_rst_ni = 0;
    #1;
    chk("rst_stx", stx_pad_o, 1);
    chk("rst_tstate", tstate, 0);
    chk("rst_count", tf_count, 0);
    chk("rst_thre", thre, 1);
    chk("rst_temt", temt, 1);
    repeat (3) @(negedge clk);
    wb_rst_ni = 1;
    @(negedge clk);

    for (int m = 0; m < 2; m++) begin
      en_mode = m;
      for (int i = 0; i < 6; i++) send_one(dir[i][15:8], dir[i][7:0]);
    end

    en_mode = 0;
    lcr = 8'h03;
    push(8'hB4, 8'h03, 1);
    wait_fall("break");
    repeat (52) @(negedge clk);
    brk_mask = 1; lcr = 8'h43;
    @(negedge clk);
    chk("break_low", stx_pad_o, 0);
    chk("break_fsm_runs", tstate, 2);
    repeat (2) @(negedge clk);
    chk("break_held", stx_pad_o, 0);
    lcr = 8'h03;
    @(negedge clk);
    chk("break_release_bit2", stx_pad_o, 1);
    brk_mask = 0;
    wait_temt("break", ticks);
    chk("break_frame_ticks", ticks + 56, 160);

    en_mode = 2;
    b2b = 0; idle_after = 0;
    for (int i = 0; i < 17; i++) push(8'(i), 8'h03, i < 16);
    chk("full_count", tf_count, 16);
    chk("full_thre", thre, 0);
    chk("full_temt", temt, 0);
    chk("frozen_stx", stx_pad_o, 1);
    en_mode = 0;
    wait_fall("burst");
    wait_temt("burst", ticks);
    chk("burst_ticks", ticks, 16 * 160);
    chk("burst_b2b", b2b, 15);
    chk("burst_idle_after", idle_after, 1);

    en_mode = 2;
    for (int i = 0; i < 6; i++) push(8'($urandom), 8'h03, 1);
    chk("txr_count_pre", tf_count, 6);
    en_mode = 0;
    wait_fall("txr");
    chk("txr_count_pop", tf_count, 5);
    repeat (5) @(negedge clk);
    tx_reset = 1; tf_push = 1; wb_dat_i = 8'hEE;
    sb.delete();
    @(negedge clk);
    tx_reset = 0; tf_push = 0;
    chk("txr_count", tf_count, 0);
    chk("txr_thre", thre, 1);
    chk("txr_temt_busy", temt, 0);
    wait_temt("txr", ticks);
    chk("txr_frame_ticks", ticks + 6, 160);
    repeat (40) @(negedge clk);
    chk("txr_idle_stx", stx_pad_o, 1);
    chk("txr_idle_state", tstate, 0);

    for (int it = 0; it < 10; it++) begin
      l = 8'($urandom_range(0, 63));
      k = $urandom_range(1, 3);
      lcr = l;
      en_mode = 2;
      for (int j = 0; j < k; j++) push(8'($urandom), l, 1);
      chk("rand_count", tf_count, k);
      en_mode = $urandom_range(0, 1);
      wait_fall("rand");
      wait_temt("rand", ticks);
      chk("rand_ticks", ticks, k * frame_len(l));
    end
    chk("sb_drained", sb.size(), 0);

    en_mode = 0;
    lcr = 8'h03;
    push(8'h5A, 8'h03, 1);
    wait_fall("rst");
    repeat (40) @(negedge clk);
    chk("rst_mid_state", tstate, 2);
    mon_on = 0;
    @(posedge clk);
    #2 wb_rst_ni = 0;
    #1;
    chk("rstmid_stx", stx_pad_o, 1);
    chk("rstmid_tstate", tstate, 0);
    chk("rstmid_count", tf_count, 0);
    chk("rstmid_temt", temt, 1);
    sb.delete();
    @(negedge clk);
    wb_rst_ni = 1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
